// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and defaults for the two-port I2C command arbiter.
package i2c_cmd_arbiter_pkg;
  localparam int I2C_W             = 24;
  localparam int N_PORTS           = 2;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_TIMEOUT_TICKS = 4095;
  localparam int DEF_GAP_TICKS     = 2;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END,
    GAP,
    DONE
  } arbStateT;

  // Counter width able to hold 0..maxVal, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction
endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Arbiter-to-I2C-controller command bus.
interface i2c_cmd_arbiter_if;
  import i2c_cmd_arbiter_pkg::*;

  // Handshake: oGO is a level request with oDATA stable while high; the controller
  // answers by pulling iEND low while busy and raising it (with iACK=1 on NACK) when done.
  logic             oGO;
  logic [I2C_W-1:0] oDATA;
  logic             iEND;
  logic             iACK;

  modport master (output oGO, output oDATA, input iEND, input iACK);
  modport slave  (input oGO, input oDATA, output iEND, output iACK);
endinterface

// File: rtl/i2c_rr_arb.sv
// Two-port round-robin grant; purely combinational, pointer lives in the parent.
module i2c_rr_arb
  import i2c_cmd_arbiter_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic               last,
  output logic [N_PORTS-1:0] gnt
);
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Arbitrates two requesters onto one I2C controller with NACK retry, gap and timeout.
module i2c_cmd_arbiter
  import i2c_cmd_arbiter_pkg::*;
#(
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int GAP_TICKS     = DEF_GAP_TICKS
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iTICK,
  input  logic                iREQ0,
  input  logic                iREQ1,
  input  logic [I2C_W-1:0]    iDATA0,
  input  logic [I2C_W-1:0]    iDATA1,
  output logic                oDONE0,
  output logic                oDONE1,
  output logic                oERR0,
  output logic                oERR1,
  output logic [N_PORTS-1:0]  oGNT,
  output logic                oBUSY,
  output arbStateT            oSTATE,
  i2c_cmd_arbiter_if.master   ctrl
);
  localparam int RW = cntWidth(MAX_RETRY);
  localparam int TW = cntWidth(TIMEOUT_TICKS);
  localparam int GW = cntWidth(GAP_TICKS);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TIMEOUT_TICKS);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TICKS);

  arbStateT           state;
  logic [RW-1:0]      retryCnt;
  logic [TW-1:0]      tickCnt;
  logic [TW-1:0]      tickNext;
  logic [GW-1:0]      gapCnt;
  logic               lastServed;
  logic [N_PORTS-1:0] rrGnt;
  logic               launchEnd;
  logic               endErr;
  logic               doRetry;

  i2c_rr_arb uRrArb (
    .req  ({iREQ1, iREQ0}),
    .last (lastServed),
    .gnt  (rrGnt)
  );

  assign tickNext = (tickCnt == TICK_MAX) ? tickCnt : tickCnt + 1'b1;
  assign oBUSY    = (state != IDLE);
  assign oSTATE   = state;

  // A completing tick wins over a timeout landing on the same tick.
  always_comb begin
    launchEnd = 1'b0;
    endErr    = 1'b0;
    doRetry   = 1'b0;
    if (iTICK) begin
      if (state == WAIT_END && ctrl.iEND) begin
        if (!ctrl.iACK) begin
          launchEnd = 1'b1;
        end else if (retryCnt < RETRY_MAX) begin
          doRetry = 1'b1;
        end else begin
          launchEnd = 1'b1;
          endErr    = 1'b1;
        end
      end else if ((state == WAIT_START || state == WAIT_END) && tickNext == TICK_MAX) begin
        launchEnd = 1'b1;
        endErr    = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      ctrl.oGO   <= 1'b0;
      ctrl.oDATA <= '0;
      oDONE0     <= 1'b0;
      oDONE1     <= 1'b0;
      oERR0      <= 1'b0;
      oERR1      <= 1'b0;
      oGNT       <= '0;
      retryCnt   <= '0;
      tickCnt    <= '0;
      gapCnt     <= '0;
      lastServed <= 1'b1;
    end else begin
      oDONE0 <= 1'b0;
      oDONE1 <= 1'b0;
      oERR0  <= 1'b0;
      oERR1  <= 1'b0;
      if (launchEnd) begin
        ctrl.oGO <= 1'b0;
        oDONE0   <= oGNT[0];
        oDONE1   <= oGNT[1];
        oERR0    <= oGNT[0] & endErr;
        oERR1    <= oGNT[1] & endErr;
        state    <= DONE;
      end else if (doRetry) begin
        ctrl.oGO <= 1'b0;
        retryCnt <= retryCnt + 1'b1;
        gapCnt   <= '0;
        state    <= GAP;
      end else begin
        case (state)
          IDLE: begin
            if (rrGnt != '0) begin
              oGNT       <= rrGnt;
              ctrl.oDATA <= rrGnt[0] ? iDATA0 : iDATA1;
              state      <= LAUNCH;
            end
          end
          LAUNCH: begin
            ctrl.oGO <= 1'b1;
            tickCnt  <= '0;
            state    <= WAIT_START;
          end
          WAIT_START: begin
            if (iTICK) begin
              tickCnt <= tickNext;
              if (!ctrl.iEND) state <= WAIT_END;
            end
          end
          WAIT_END: begin
            if (iTICK) tickCnt <= tickNext;
          end
          GAP: begin
            if (gapCnt >= GAP_MAX) state <= LAUNCH;
            else if (iTICK) gapCnt <= gapCnt + 1'b1;
          end
          DONE: begin
            lastServed <= oGNT[1];
            retryCnt   <= '0;
            oGNT       <= '0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench: two requesters, a behavioural I2C controller and a transaction-level scoreboard.
module tb_i2c_cmd_arbiter;
  import i2c_cmd_arbiter_pkg::*;

  localparam int MAX_RETRY     = 3;
  localparam int TIMEOUT_TICKS = 8;
  localparam int GAP_TICKS     = 2;
  localparam int WAIT_LIMIT    = 3000;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iTICK  = 1'b0;
  logic        iREQ0  = 1'b0;
  logic        iREQ1  = 1'b0;
  logic [23:0] iDATA0 = '0;
  logic [23:0] iDATA1 = '0;
  logic        oDONE0, oDONE1, oERR0, oERR1, oBUSY;
  logic [1:0]  oGNT;
  arbStateT    oSTATE;

  i2c_cmd_arbiter_if bus ();

  i2c_cmd_arbiter #(
    .MAX_RETRY     (MAX_RETRY),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .GAP_TICKS     (GAP_TICKS)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iTICK  (iTICK),
    .iREQ0  (iREQ0),
    .iREQ1  (iREQ1),
    .iDATA0 (iDATA0),
    .iDATA1 (iDATA1),
    .oDONE0 (oDONE0),
    .oDONE1 (oDONE1),
    .oERR0  (oERR0),
    .oERR1  (oERR1),
    .oGNT   (oGNT),
    .oBUSY  (oBUSY),
    .oSTATE (oSTATE),
    .ctrl   (bus)
  );

  // clock / watchdog
  always #5 iCLK = ~iCLK;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nErrors, nChecks);
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          nErrors = 0;
  int          nChecks = 0;
  logic [23:0] launchQ[$];   // expected oDATA for each launch
  logic [1:0]  doneQ[$];     // expected {port, err} per transaction
  logic [1:0]  ackQ[$];      // controller answer per launch: 0 ack, 1 nack, 2 never start
  int          planQ[$];     // forced NACK count for the next grant, -1 = stuck controller
  int          servedQ[$];
  int          launchCnt  = 0;
  int          doneEvents = 0;
  int          txnIssued  = 0;
  int          errNoDone  = 0;
  int          gntBoth    = 0;
  int          busyBad    = 0;
  int          dataMoved  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_req(input int p, input logic v, input logic [23:0] d);
    if (p == 0) begin
      iREQ0  = v;
      iDATA0 = d;
    end else begin
      iREQ1  = v;
      iDATA1 = d;
    end
  endtask

  task automatic do_txn(input int p, input logic [23:0] d, input bit keep);
    int cyc;
    @(negedge iCLK); #1;
    set_req(p, 1'b1, d);
    txnIssued++;
    cyc = 0;
    do begin
      @(negedge iCLK);
      cyc++;
    end while (!(p == 0 ? oDONE0 : oDONE1) && cyc < WAIT_LIMIT);
    if (cyc >= WAIT_LIMIT) check("txn_timeout", 32'(p == 0 ? oDONE0 : oDONE1), 1);
    #1;
    if (!keep) set_req(p, 1'b0, d);
  endtask

  task automatic run_port(input int p, input int n, input int maxIdle);
    for (int k = 0; k < n; k++) begin
      do_txn(p, 24'($urandom), (maxIdle == 0) && (k < n - 1));
      if (maxIdle != 0) repeat ($urandom_range(0, maxIdle)) @(negedge iCLK);
    end
  endtask

  // Reference model, invariant monitors and behavioural I2C controller.
  initial begin : bus_model
    int          phase, cnt, port, plan, nLaunch, lowTicks, highTicks, launchInTxn;
    logic        goPrev, lastModel, wasTick, err, ep, ee;
    logic [1:0]  gntPrev, curCode;
    logic [23:0] dataAtLaunch;
    phase = 0; cnt = 0; lowTicks = 0; highTicks = 0; launchInTxn = 0;
    goPrev = 1'b0; gntPrev = '0; lastModel = 1'b1; curCode = '0; dataAtLaunch = '0;
    bus.iEND = 1'b1;
    bus.iACK = 1'b0;
    forever begin
      @(negedge iCLK);
      wasTick = iTICK;
      if (!iRST_N) begin
        phase = 0; lowTicks = 0; highTicks = 0; launchInTxn = 0;
        goPrev = 1'b0; gntPrev = '0; lastModel = 1'b1;
        bus.iEND = 1'b1;
        bus.iACK = 1'b0;
        iTICK = 1'b0;
        launchQ.delete();
        doneQ.delete();
        ackQ.delete();
        continue;
      end
      if ((oERR0 && !oDONE0) || (oERR1 && !oDONE1)) errNoDone++;
      if (oGNT == 2'b11) gntBoth++;
      if (oGNT != 2'b00 && !oBUSY) busyBad++;
      if (goPrev && bus.oGO && bus.oDATA != dataAtLaunch) dataMoved++;
      if (wasTick) begin
        if (goPrev) highTicks++;
        else lowTicks++;
      end

      // grant: both pending -> the port not served last, else the only one pending
      if (gntPrev == 2'b00 && oGNT != 2'b00) begin
        if (iREQ0 && iREQ1) port = lastModel ? 0 : 1;
        else port = iREQ0 ? 0 : 1;
        check("grant_port", 32'(oGNT), 32'(1) << port);
        servedQ.push_back(oGNT[1] ? 1 : 0);
        lastModel = (port == 1);
        if (planQ.size() != 0) plan = planQ.pop_front();
        else if ($urandom_range(0, 9) == 0) plan = -1;
        else plan = int'($urandom_range(0, 4));
        if (plan < 0) begin
          nLaunch = 1;
          err     = 1'b1;
        end else begin
          nLaunch = (plan > MAX_RETRY) ? MAX_RETRY + 1 : plan + 1;
          err     = (plan > MAX_RETRY);
        end
        for (int i = 0; i < nLaunch; i++) begin
          launchQ.push_back(port == 0 ? iDATA0 : iDATA1);
          ackQ.push_back(plan < 0 ? 2'd2 : (i < plan ? 2'd1 : 2'd0));
        end
        doneQ.push_back({port == 1, err});
        launchInTxn = 0;
      end

      if (!goPrev && bus.oGO) begin
        launchCnt++;
        check("launch_expected", 32'(launchQ.size() != 0), 1);
        if (launchQ.size() != 0) check("launch_data", 32'(bus.oDATA), 32'(launchQ.pop_front()));
        if (launchInTxn > 0) check("gap_ticks", 32'(lowTicks >= GAP_TICKS), 1);
        launchInTxn++;
        highTicks    = 0;
        dataAtLaunch = bus.oDATA;
      end
      if (goPrev && !bus.oGO) begin
        if (curCode == 2'd2) check("timeout_ticks", 32'(highTicks), TIMEOUT_TICKS);
        lowTicks = 0;
      end

      if (oDONE0 || oDONE1) begin
        doneEvents++;
        check("done_expected", 32'(doneQ.size() != 0), 1);
        if (doneQ.size() != 0) begin
          {ep, ee} = doneQ.pop_front();
          check("done_port_err", {29'd0, oDONE1, oDONE0, oERR0 | oERR1}, {29'd0, ep, ~ep, ee});
        end
        check("launches_left", 32'(launchQ.size()), 0);
      end

      case (phase)
        0: if (bus.oGO) begin
          curCode = (ackQ.size() != 0) ? ackQ.pop_front() : 2'd0;
          cnt     = int'($urandom_range(1, 2));
          phase   = 1;
        end
        1: if (!bus.oGO) phase = 0;
           else if (wasTick && curCode != 2'd2) begin
             cnt--;
             if (cnt == 0) begin
               bus.iEND = 1'b0;
               bus.iACK = 1'b0;
               cnt      = int'($urandom_range(1, 3));
               phase    = 2;
             end
           end
        2: if (wasTick) begin
          cnt--;
          if (cnt == 0) begin
            bus.iEND = 1'b1;
            bus.iACK = (curCode == 2'd1);
            phase    = 3;
          end
        end
        default: if (!bus.oGO) phase = 0;
      endcase

      goPrev  = bus.oGO;
      gntPrev = oGNT;
      iTICK   = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin : main
    int l0, s0, cyc;
    repeat (3) @(negedge iCLK);
    #1;
    check("rst_go", 32'(bus.oGO), 0);
    check("rst_data", 32'(bus.oDATA), 0);
    check("rst_gnt", 32'(oGNT), 0);
    check("rst_busy", 32'(oBUSY), 0);
    check("rst_done_err", {28'd0, oDONE0, oDONE1, oERR0, oERR1}, 0);
    check("rst_state", 32'(oSTATE), 32'(IDLE));
    @(negedge iCLK); #1;
    iRST_N = 1'b1;

    // both ports request together and hold: alternate starting with port 0
    fork
      run_port(0, 2, 0);
      run_port(1, 2, 0);
    join
    check("rr_count", 32'(servedQ.size()), 4);
    if (servedQ.size() >= 4)
      for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), 32'(servedQ[i]), i % 2);

    // single ACKed transfer
    planQ.push_back(0);
    l0 = launchCnt;
    do_txn(0, 24'h401500, 1'b0);
    check("ack_launches", 32'(launchCnt - l0), 1);
    check("ack_data_held", 32'(bus.oDATA), 32'h401500);

    // NACK every time: initial launch plus MAX_RETRY relaunches, then error
    planQ.push_back(4);
    l0 = launchCnt;
    do_txn(1, 24'h2A_3C_5E, 1'b0);
    check("nack_all_launches", 32'(launchCnt - l0), MAX_RETRY + 1);

    // NACK then ACK
    planQ.push_back(1);
    l0 = launchCnt;
    do_txn(0, 24'h12_34_56, 1'b0);
    check("nack_ack_launches", 32'(launchCnt - l0), 2);

    // controller never starts: timeout
    planQ.push_back(-1);
    l0 = launchCnt;
    do_txn(1, 24'h77_00_11, 1'b0);
    check("timeout_launches", 32'(launchCnt - l0), 1);

    fork
      run_port(0, 15, 6);
      run_port(1, 15, 6);
    join

    // reset while a transfer is in flight
    repeat (5) @(negedge iCLK);
    planQ.push_back(0);
    #1;
    set_req(1, 1'b1, 24'h5A5A5A);
    cyc = 0;
    while (oSTATE != WAIT_END && cyc < WAIT_LIMIT) begin
      @(negedge iCLK);
      cyc++;
    end
    check("mid_reach_wait_end", 32'(oSTATE == WAIT_END), 1);
    #2;
    iRST_N = 1'b0;
    #1;
    check("mid_rst_go", 32'(bus.oGO), 0);
    check("mid_rst_gnt", 32'(oGNT), 0);
    check("mid_rst_busy", 32'(oBUSY), 0);
    check("mid_rst_state", 32'(oSTATE), 32'(IDLE));
    set_req(1, 1'b0, 24'h0);
    repeat (3) @(negedge iCLK);
    #1;
    iRST_N = 1'b1;
    planQ.push_back(0);
    planQ.push_back(0);
    s0 = servedQ.size();
    fork
      do_txn(0, 24'hC0FFEE, 1'b0);
      do_txn(1, 24'hBEEF01, 1'b0);
    join
    check("post_rst_count", 32'(servedQ.size() - s0), 2);
    if (servedQ.size() > s0) check("post_rst_first", 32'(servedQ[s0]), 0);

    repeat (20) @(negedge iCLK);
    check("done_events", 32'(doneEvents), 32'(txnIssued));
    check("done_pending", 32'(doneQ.size()), 0);
    check("launch_pending", 32'(launchQ.size()), 0);
    check("err_without_done", 32'(errNoDone), 0);
    check("gnt_both", 32'(gntBoth), 0);
    check("gnt_not_busy", 32'(busyBad), 0);
    check("data_moved_during_go", 32'(dataMoved), 0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: re-launches allowed after a NACK before an error is reported.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 4095: maximum iTICK count per launch before abort.
REQ-003 SHALL have parameter GAP_TICKS, default 2: minimum iTICK count with oGO low between launches.
REQ-004 iCLK  input  1  system clock; all logic is clocked on the rising edge.
REQ-005 iRST_N  input  1  asynchronous, active-low reset.
REQ-006 iTICK  input  1  one-iCLK pulse per I2C controller work-clock period; iEND and iACK are sampled only when iTICK=1.
REQ-007 iREQ0 / iREQ1  input  1  per-port transaction request, held high until the matching oDONE.
REQ-008 iDATA0 / iDATA1  input  24  per-port {slave addr, sub addr, data}, stable while the port's iREQ is high.
REQ-009 oDONE0 / oDONE1  output  1  one-cycle completion pulse.
REQ-010 oERR0 / oERR1  output  1  valid with oDONE; 1 means retries exhausted or timeout.
REQ-011 oGO  output  1  transfer start to the I2C controller.
REQ-012 oDATA  output  24  transfer word to the I2C controller.
REQ-013 iEND  input  1  controller end flag; goes low while busy and stays high when finished.
REQ-014 iACK  input  1  controller ack flag; 1 = NACK seen.
REQ-015 oGNT  output  2  one-hot current owner, 00 when idle.
REQ-016 oBUSY  output  1  1 in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, LAUNCH, WAIT_START, WAIT_END, GAP, DONE.
REQ-018 IDLE: on any iREQ, grant round-robin and go to LAUNCH.
 - Both ports requesting: grant the port not served last.
 - Last-served pointer resets to port 1, so port 0 wins first.
REQ-019 SHALL latch the granted iDATA into oDATA when the grant is made, and SHALL hold oDATA constant until DONE.
REQ-020 LAUNCH: set oGO=1, clear the tick counter, go to WAIT_START.
REQ-021 WAIT_START: on a tick with iEND=0, go to WAIT_END.
REQ-022 WAIT_END: on a tick with iEND=1, drop oGO.
 - iACK=0: go to DONE, err=0.
 - iACK=1 and retries < MAX_RETRY: increment retries, go to GAP.
 - Otherwise: go to DONE, err=1.
REQ-023 GAP: hold oGO=0 for GAP_TICKS ticks, then go to LAUNCH with the same oDATA.
REQ-024 SHALL count ticks in WAIT_START+WAIT_END; on reaching TIMEOUT_TICKS, drop oGO and go to DONE with err=1 (no retry).
REQ-025 DONE: pulse the granted oDONE for exactly one iCLK, with oERR driven per REQ-022/REQ-024 and oERR of the other port held 0.
 - Update the last-served pointer, clear retries, return to IDLE.
REQ-026 oDONE SHALL occur no earlier than 1 iCLK after the deciding tick; the earliest next grant SHALL be 1 iCLK after DONE.
REQ-027 Requests SHALL NOT be preempted; a request dropped mid-transaction SHALL be ignored and the transaction still completes with oDONE.
REQ-028 A request arriving while busy SHALL wait; no request SHALL be lost.
REQ-029 Retry and tick counters SHALL saturate and never wrap; widths SHALL be clog2(MAX_RETRY+1) and clog2(TIMEOUT_TICKS+1).
REQ-030 oERR SHALL be 0 whenever the corresponding oDONE is 0.

Reset
REQ-031 Asserting iRST_N low at any time SHALL immediately set:
 - state = IDLE;
 - oGO, oDONE*, oERR*, oBUSY = 0; oGNT = 00;
 - oDATA = 0; counters = 0; last-served = port 1.
REQ-032 An in-flight transaction SHALL be abandoned without oDONE; requesters re-request after reset.

Structure
REQ-033 A shared package SHALL hold:
 - state enum;
 - default MAX_RETRY / TIMEOUT_TICKS / GAP_TICKS;
 - I2C word width (24);
 - port count (2).
REQ-034 The round-robin grant logic SHALL live in sub-module i2c_rr_arb: inputs req[1:0], last; outputs one-hot gnt. It is purely combinational; the pointer register stays in the parent.

Verification
REQ-035 Single port 0 request, iDATA0=24'h40_1500, controller ACKs -> oGO high until iEND rises, oDATA=24'h401500, one oDONE0, oERR0=0.
REQ-036 iREQ0 and iREQ1 asserted in the same cycle after reset, held continuously -> service order 0,1,0,1; oGNT never 11.
REQ-037 Controller NACKs every time, MAX_RETRY=3 -> exactly 4 oGO pulses, each separated by >=2 low ticks, then oDONE with oERR=1.
REQ-038 NACK then ACK -> exactly 2 launches with identical oDATA, oERR=0.
REQ-039 iEND stuck high after GO, TIMEOUT_TICKS=8 -> oGO drops after 8 ticks, oERR=1.
REQ-040 iRST_N pulsed low during WAIT_END -> oGO=0 the same cycle, no oDONE; after release, a new request is served with port 0 priority.
